// File: rtl/spi_controller.sv
// spi_controller: SPI mode-0 master (CPOL=0, CPHA=0), MSB first, single usb_clk domain.
// Build option: define SPI_CTRL_LOOPBACK_EN to shift in the internal pico line instead of poci.
module spi_controller #(
  parameter int unsigned pCLK_DIV    = 4,
  parameter int unsigned pDATA_WIDTH = 8
) (
  input  logic                   usb_clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [pDATA_WIDTH-1:0] tx_data,
  output logic [pDATA_WIDTH-1:0] rx_data,
  output logic                   busy,
  output logic                   done,
  output logic                   sclk,
  output logic                   cs_n,
  output logic                   pico,
  input  logic                   poci
);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_e;

  // Counters are sized for pCLK_DIV=255 and pDATA_WIDTH=32 so they never wrap mid-transfer.
  localparam logic [7:0] DIV_LAST  = 8'(pCLK_DIV - 1);
  localparam logic [5:0] HALF_LAST = 6'(2 * pDATA_WIDTH - 1);
  localparam logic [5:0] FALL_LAST = 6'(2 * pDATA_WIDTH - 2);

  state_e                 state_q;
  logic [7:0]             div_q;
  logic [5:0]             half_q;
  logic [pDATA_WIDTH-1:0] tx_sh_q;
  logic [pDATA_WIDTH-1:0] rx_sh_q;
  logic [pDATA_WIDTH-1:0] rx_sh_d;
  logic [pDATA_WIDTH-1:0] rx_q;
  logic                   sclk_q;
  logic                   cs_n_q;
  logic                   pico_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   div_last;
  logic                   sdi;

  assign div_last = (div_q == DIV_LAST);

`ifdef SPI_CTRL_LOOPBACK_EN
  assign sdi = pico_q;
`else
  assign sdi = poci;
`endif

  assign rx_sh_d = {rx_sh_q[pDATA_WIDTH-2:0], sdi};

  // NOTE: every register below is assigned non-blocking, so each branch reads pre-edge values.
  always_ff @(posedge usb_clk) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      half_q  <= '0;
      tx_sh_q <= '0;
      rx_sh_q <= '0;
      rx_q    <= '0;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      pico_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= SETUP;
            busy_q  <= 1'b1;
            cs_n_q  <= 1'b0;
            tx_sh_q <= tx_data;
            pico_q  <= tx_data[pDATA_WIDTH-1];
            div_q   <= '0;
          end
        end

        SETUP: begin
          if (div_last) begin
            // The first rising edge opens SHIFT and samples bit MSB.
            state_q <= SHIFT;
            div_q   <= '0;
            half_q  <= '0;
            sclk_q  <= 1'b1;
            rx_sh_q <= rx_sh_d;
          end else begin
            div_q <= div_q + 8'd1;
          end
        end

        SHIFT: begin
          if (div_last) begin
            div_q <= '0;
            if (half_q == HALF_LAST) begin
              state_q <= HOLD;
              cs_n_q  <= 1'b1;
            end else begin
              half_q <= half_q + 6'd1;
              sclk_q <= ~sclk_q;
              if (sclk_q) begin
                // Falling edge: present the next bit, except after the final one.
                if (half_q != FALL_LAST) begin
                  pico_q  <= tx_sh_q[pDATA_WIDTH-2];
                  tx_sh_q <= tx_sh_q << 1;
                end
              end else begin
                rx_sh_q <= rx_sh_d;
              end
            end
          end else begin
            div_q <= div_q + 8'd1;
          end
        end

        HOLD: begin
          if (div_last) begin
            state_q <= IDLE;
            div_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            rx_q    <= rx_sh_q;
          end else begin
            div_q <= div_q + 8'd1;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_data = rx_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign sclk    = sclk_q;
  assign cs_n    = cs_n_q;
  assign pico    = pico_q;

endmodule

// File: tb/tb_spi_controller.sv
// tb_spi_controller: directed scoreboard bench for spi_controller at defaults and at
// pCLK_DIV=1 / pDATA_WIDTH=16; expectations follow SPI_CTRL_LOOPBACK_EN when defined.
module tb_spi_controller;

  localparam int W    = 8;
  localparam int D    = 4;
  localparam int LAT  = (2 * W + 2) * D + 1;
  localparam int W2   = 16;
  localparam int LAT2 = (2 * W2 + 2) * 1 + 1;

  logic usb_clk = 1'b0;
  always #5 usb_clk = ~usb_clk;

  logic         rst;
  logic         start;
  logic [W-1:0] tx_data;
  logic [W-1:0] rx_data;
  logic         busy, done, sclk, cs_n, pico;
  logic         poci = 1'b0;

  logic          start2;
  logic [W2-1:0] tx2;
  logic [W2-1:0] rx2;
  logic          busy2, done2, sclk2, cs_n2, pico2;
  logic          poci2 = 1'b0;

  spi_controller #(.pCLK_DIV(D), .pDATA_WIDTH(W)) dut (
    .usb_clk(usb_clk), .rst(rst), .start(start), .tx_data(tx_data), .rx_data(rx_data),
    .busy(busy), .done(done), .sclk(sclk), .cs_n(cs_n), .pico(pico), .poci(poci)
  );

  spi_controller #(.pCLK_DIV(1), .pDATA_WIDTH(W2)) dut2 (
    .usb_clk(usb_clk), .rst(rst), .start(start2), .tx_data(tx2), .rx_data(rx2),
    .busy(busy2), .done(done2), .sclk(sclk2), .cs_n(cs_n2), .pico(pico2), .poci(poci2)
  );

  typedef struct {
    logic [W-1:0] rx;
    logic [W-1:0] tx;
    int           due;
  } exp_t;

  exp_t sb[$];
  exp_t e_pop;

  int cyc    = 0;
  int n_vec  = 0;
  int n_bad  = 0;
  int n_done = 0;

  logic [W-1:0]  periph_word  = '0;
  logic [W-1:0]  per_sh       = '0;
  logic [W-1:0]  pico_cap     = '0;
  logic          sclk_prev    = 1'b0;
  logic          cs_prev      = 1'b1;
  logic [W2-1:0] periph2_word = '0;
  logic [W2-1:0] per2_sh      = '0;
  logic          sclk2_prev   = 1'b0;
  logic          cs2_prev     = 1'b1;

  always @(posedge usb_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] exp_rx(input logic [W-1:0] tx, input logic [W-1:0] per);
`ifdef SPI_CTRL_LOOPBACK_EN
    return tx;
`else
    return per;
`endif
  endfunction

  // Peripheral model + pico capture + scoreboard pop for the default instance.
  always @(negedge usb_clk) begin
    if (cs_prev && !cs_n) begin
      per_sh   = periph_word;
      pico_cap = '0;
    end else if (sclk_prev && !sclk && !cs_n) begin
      per_sh = per_sh << 1;
    end
    poci = per_sh[W-1];
    if (!sclk_prev && sclk) pico_cap = {pico_cap[W-2:0], pico};
    if (done) begin
      n_done++;
      if (sb.size() == 0) begin
        check("unexpected_done", {31'd0, done}, 32'd0);
      end else begin
        e_pop = sb.pop_front();
        check("rx_data", {24'd0, rx_data}, {24'd0, e_pop.rx});
        check("done_cycle", cyc, e_pop.due);
        check("pico_bits", {24'd0, pico_cap}, {24'd0, e_pop.tx});
      end
    end
    sclk_prev = sclk;
    cs_prev   = cs_n;
  end

  // Echo peripheral for the 16-bit, divide-by-1 instance.
  always @(negedge usb_clk) begin
    if (cs2_prev && !cs_n2) per2_sh = periph2_word;
    else if (sclk2_prev && !sclk2 && !cs_n2) per2_sh = per2_sh << 1;
    poci2      = per2_sh[W2-1];
    sclk2_prev = sclk2;
    cs2_prev   = cs_n2;
  end

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge usb_clk);
      n++;
    end
    check("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    int n;
    rst = 1'b1; start = 1'b0; tx_data = '0; start2 = 1'b0; tx2 = '0;
    repeat (3) @(negedge usb_clk);
    check("rst_sclk", {31'd0, sclk}, 32'd0);
    check("rst_cs_n", {31'd0, cs_n}, 32'd1);
    check("rst_pico", {31'd0, pico}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_rx", {24'd0, rx_data}, 32'd0);
    check("rst_cs_n2", {31'd0, cs_n2}, 32'd1);
    rst = 1'b0;
    @(negedge usb_clk);

    // Transfer A5 against a peripheral returning 3C; a stray start at cycle 10 must be ignored.
    periph_word = 8'h3C;
    tx_data = 8'hA5; start = 1'b1; t0 = cyc;
    sb.push_back('{rx: exp_rx(8'hA5, 8'h3C), tx: 8'hA5, due: t0 + LAT});
    @(negedge usb_clk);
    start = 1'b0; tx_data = 8'h00;
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    check("cs_n_after_accept", {31'd0, cs_n}, 32'd0);
    check("pico_msb_after_accept", {31'd0, pico}, 32'd1);
    while (cyc < t0 + 10) @(negedge usb_clk);
    start = 1'b1; tx_data = 8'hFF;
    @(negedge usb_clk);
    start = 1'b0; tx_data = 8'h00;
    wait_idle(200);
    repeat (5) @(negedge usb_clk);
    check("rx_hold", {24'd0, rx_data}, {24'd0, exp_rx(8'hA5, 8'h3C)});
    check("done_count_t1", n_done, 1);

    // Abort at cycle 30; start during reset must not launch a transfer.
    periph_word = 8'h77;
    tx_data = 8'h99; start = 1'b1; t0 = cyc;
    @(negedge usb_clk);
    start = 1'b0;
    while (cyc < t0 + 30) @(negedge usb_clk);
    rst = 1'b1;
    @(negedge usb_clk);
    check("abort_cs_n", {31'd0, cs_n}, 32'd1);
    check("abort_sclk", {31'd0, sclk}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_rx", {24'd0, rx_data}, 32'd0);
    start = 1'b1;
    @(negedge usb_clk);
    rst = 1'b0; start = 1'b0;
    check("start_in_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge usb_clk);
    check("start_in_rst_cs_n", {31'd0, cs_n}, 32'd1);
    repeat (100) @(negedge usb_clk);
    check("done_count_abort", n_done, 1);

    // Peripheral ties poci low: rx is 00, or 5A when looped back internally.
    periph_word = 8'h00;
    tx_data = 8'h5A; start = 1'b1; t0 = cyc;
    sb.push_back('{rx: exp_rx(8'h5A, 8'h00), tx: 8'h5A, due: t0 + LAT});
    @(negedge usb_clk);
    start = 1'b0;
    wait_idle(200);
    @(negedge usb_clk);

    // Back-to-back: start held through the done cycle.
    periph_word = 8'h3C;
    tx_data = 8'h11; start = 1'b1; t0 = cyc;
    sb.push_back('{rx: exp_rx(8'h11, 8'h3C), tx: 8'h11, due: t0 + LAT});
    sb.push_back('{rx: exp_rx(8'h12, 8'hC3), tx: 8'h12, due: t0 + 2 * LAT});
    @(negedge usb_clk);
    tx_data = 8'h12;
    @(negedge usb_clk);
    periph_word = 8'hC3;
    while (cyc < t0 + LAT) @(negedge usb_clk);
    check("b2b_cs_n_in_done", {31'd0, cs_n}, 32'd1);
    @(negedge usb_clk);
    start = 1'b0;
    check("b2b_cs_n_relow", {31'd0, cs_n}, 32'd0);
    check("b2b_busy_relow", {31'd0, busy}, 32'd1);
    wait_idle(200);
    @(negedge usb_clk);

    // pCLK_DIV=1, pDATA_WIDTH=16, echoing peripheral.
    periph2_word = 16'h8001;
    tx2 = 16'h8001; start2 = 1'b1; t0 = cyc;
    @(negedge usb_clk);
    start2 = 1'b0; tx2 = '0;
    n = 0;
    while (!done2 && n < 100) begin
      @(negedge usb_clk);
      n++;
    end
    check("d1_done_seen", {31'd0, done2}, 32'd1);
    check("d1_done_cycle", cyc, t0 + LAT2);
    check("d1_rx", {16'd0, rx2}, 32'h8001);

    repeat (5) @(negedge usb_clk);
    check("done_pulses_total", n_done, 4);
    check("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
